// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared constants and helpers for the dff_pipe delay line.
// Clock-polarity encodings, legal parameter ranges and a clog2 that never
// returns less than one bit (used for FILL and TAP_SEL widths).
package dff_pipe_pkg;

  localparam logic CLK_POL_NEG = 1'b0;
  localparam logic CLK_POL_POS = 1'b1;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 256;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 64;

  // Bit width needed to hold values 0..n-1, but never narrower than 1 bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one WIDTH-bit register of the pipeline.
// Async active-low reset and sync clear both load INIT; clear beats enable.
// CLK_POL picks the active edge; the other edge never touches state.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic             CLK_POL = CLK_POL_NEG,
  parameter logic [WIDTH-1:0] INIT    = '0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic             SCLR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Next state: clear, else load when enabled, else hold.
  always_comb begin
    q_d = q_q;
    if (SCLR)    q_d = INIT;
    else if (CE) q_d = D;
  end

  if (CLK_POL == CLK_POL_POS) begin : g_pos
    // Rising-edge register with async reset to INIT.
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) q_q <= INIT;
      else         q_q <= q_d;
    end
  end else begin : g_neg
    // Falling-edge register with async reset to INIT.
    always_ff @(negedge CLK or negedge RESETN) begin
      if (!RESETN) q_q <= INIT;
      else         q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage register pipeline with selectable clock
// edge, INIT value, sync clear, clock enable and fill/valid tracking.
// Optional macro DFF_PIPE_TAP_EN adds TAP_SEL/TAP_Q for reading any stage.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 4,
  parameter logic             CLK_POL = CLK_POL_NEG,
  parameter logic [WIDTH-1:0] INIT    = '0
) (
  input  logic                               CLK,
  input  logic                               RESETN,
  input  logic                               CE,
  input  logic                               SCLR,
  input  logic [WIDTH-1:0]                   D,
  output logic [WIDTH-1:0]                   Q,
  output logic [clog2_min1(DEPTH+1)-1:0]     FILL,
  output logic                               VALID
`ifdef DFF_PIPE_TAP_EN
  ,
  input  logic [clog2_min1(DEPTH)-1:0]       TAP_SEL,
  output logic [WIDTH-1:0]                   TAP_Q
`endif
);

  localparam int            FW       = clog2_min1(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  // Reject out-of-range configurations at elaboration time.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("dff_pipe: WIDTH out of range 1..256");
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("dff_pipe: DEPTH out of range 1..64");
  end

  // ---------------------------------------------------------------------
  // Stage chain: stage 0 takes D, stage k takes stage k-1.
  // ---------------------------------------------------------------------
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] din;
    if (k == 0) begin : g_head
      assign din = D;
    end else begin : g_link
      assign din = stage_q[k-1];
    end

    dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .CLK_POL (CLK_POL),
      .INIT    (INIT)
    ) u_stage (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .CE      (CE),
      .SCLR    (SCLR),
      .D       (din),
      .Q       (stage_q[k])
    );
  end

  // ---------------------------------------------------------------------
  // Fill counter: counts enabled shifts, saturates at DEPTH.
  // ---------------------------------------------------------------------
  logic [FW-1:0] fill_q, fill_d;

  // Next fill: clear to zero, else bump on an enabled shift until full.
  always_comb begin
    fill_d = fill_q;
    if (SCLR)                          fill_d = '0;
    else if (CE && fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
  end

  if (CLK_POL == CLK_POL_POS) begin : g_fill_pos
    // Rising-edge fill register; controls must be known on an active edge.
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        fill_q <= '0;
      end else begin
        assert (!$isunknown({CE, SCLR}));
        fill_q <= fill_d;
      end
    end
  end else begin : g_fill_neg
    // Falling-edge fill register; controls must be known on an active edge.
    always_ff @(negedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        fill_q <= '0;
      end else begin
        assert (!$isunknown({CE, SCLR}));
        fill_q <= fill_d;
      end
    end
  end

  assign Q     = stage_q[DEPTH-1];
  assign FILL  = fill_q;
  // Valid is a straight compare of the registered count, no extra delay.
  assign VALID = (fill_q == FILL_MAX);

`ifdef DFF_PIPE_TAP_EN
  // Tap mux: out-of-range selects fall back to the last stage.
  always_comb begin
    TAP_Q = stage_q[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(TAP_SEL) == k) TAP_Q = stage_q[k];
    end
  end
`endif

endmodule
